// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer driving one shared external 1-bit full adder cell, LSB first
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_fa_x,
    output logic             o_fa_y,
    output logic             o_fa_cin,
    input  logic             i_fa_sum,
    input  logic             i_fa_cout
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_areg;
    logic [WIDTH-1:0] r_breg;
    logic [WIDTH-1:0] r_sreg;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [WIDTH-1:0] w_sreg_next;
    // Partial result with the freshly computed bit entering at the top; the shift form keeps WIDTH=1 legal.
    assign w_sreg_next = WIDTH'({i_fa_sum, r_sreg} >> 1);
    // The cell only sees live operand bits while running; r_busy mirrors the RUN state.
    assign o_fa_x   = r_busy & r_areg[0];
    assign o_fa_y   = r_busy & r_breg[0];
    assign o_fa_cin = r_busy & r_carry;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_sum    = r_sum;
    assign o_cout   = r_cout;
    // Sequencer: capture operands on start, feed one bit pair per clock, publish the result on the last bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_areg  <= '0;
            r_breg  <= '0;
            r_sreg  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_areg  <= i_a;
                        r_breg  <= i_b;
                        r_carry <= i_cin;
                        r_sreg  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sreg  <= w_sreg_next;
                    r_carry <= i_fa_cout;
                    r_areg  <= r_areg >> 1;
                    r_breg  <= r_breg >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_sreg_next;
                        r_cout  <= i_fa_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of the serial adder sequencer against arithmetic a+b+cin
module tb_serial_add_ctrl;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         fx;
    logic         fy;
    logic         fc;
    logic         fs;
    logic         fco;
    logic         s1;
    logic         a1;
    logic         b1;
    logic         c1;
    logic         busy1;
    logic         done1;
    logic         sum1;
    logic         cout1;
    logic         fx1;
    logic         fy1;
    logic         fc1;
    logic         fs1;
    logic         fco1;
    int           n_pass = 0;
    int           n_tot = 0;
    logic [W-1:0] exp_sum;
    logic         exp_cout;

    always #5 clk = ~clk;

    // External full adder cells, purely combinational.
    assign fs   = fx ^ fy ^ fc;
    assign fco  = (fx & fy) | (fx & fc) | (fy & fc);
    assign fs1  = fx1 ^ fy1 ^ fc1;
    assign fco1 = (fx1 & fy1) | (fx1 & fc1) | (fy1 & fc1);

    serial_add_ctrl #(.WIDTH(W)) u8 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin),
        .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout),
        .o_fa_x(fx), .o_fa_y(fy), .o_fa_cin(fc), .i_fa_sum(fs), .i_fa_cout(fco)
    );

    serial_add_ctrl #(.WIDTH(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_start(s1), .i_a(a1), .i_b(b1), .i_cin(c1),
        .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1),
        .o_fa_x(fx1), .o_fa_y(fy1), .o_fa_cin(fc1), .i_fa_sum(fs1), .i_fa_cout(fco1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One operation on the WIDTH=8 unit, called one step after an edge with the unit idle.
    // hold keeps start high and scrambles the inputs while the operation runs.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc, input bit hold);
        logic [W:0] total;
        logic [W:0] part;
        logic [W:0] mask;
        total = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
        start = 1'b1;
        a = oa;
        b = ob;
        cin = oc;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k < W; k++) begin
            mask = ((W+1)'(1) << k) - 1'b1;
            part = (({1'b0, oa} & mask) + ({1'b0, ob} & mask) + (W+1)'(oc)) >> k;
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("bit_x", fx, oa[k]);
            chk("bit_y", fy, ob[k]);
            chk("bit_cin", fc, part[0]);
            chk("run_hold_result", {cout, sum}, {exp_cout, exp_sum});
            if (hold) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        {exp_cout, exp_sum} = total;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
        chk("done_fa_zero", {fx, fy, fc}, 0);
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_fa_zero", {fx, fy, fc}, 0);
        chk("idle_hold_result", {cout, sum}, {exp_cout, exp_sum});
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        s1 = 1'b0;
        a1 = 1'b0;
        b1 = 1'b0;
        c1 = 1'b0;
        exp_sum = '0;
        exp_cout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_fa", {fx, fy, fc}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        chk("dir_5a_3c", {cout, sum}, 9'h096);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("dir_ff_01", {cout, sum}, 9'h100);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        chk("dir_ff_ff_1", {cout, sum}, 9'h1FF);
        for (int i = 0; i < 6; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        start = 1'b0;
        // WIDTH=1 unit: done follows busy by one cycle.
        s1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        c1 = 1'b1;
        @(posedge clk); #1;
        s1 = 1'b0;
        chk("w1_busy", busy1, 1);
        chk("w1_fa", {fx1, fy1, fc1}, 3'b111);
        @(posedge clk); #1;
        chk("w1_done", done1, 1);
        chk("w1_busy_low", busy1, 0);
        chk("w1_sum", sum1, 1);
        chk("w1_cout", cout1, 1);
        @(posedge clk); #1;
        chk("w1_done_low", done1, 0);
        // Reset in the middle of a run.
        start = 1'b1;
        a = 8'hA7;
        b = 8'h6E;
        cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        exp_sum = '0;
        exp_cout = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            chk("arst_no_done", {busy, done}, 0);
            @(posedge clk); #1;
        end
        run_op(8'h01, 8'h01, 1'b0, 1'b0);
        chk("post_rst_1_1", {cout, sum}, 9'h002);
        for (int i = 0; i < 1000; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
